// File: rtl/ipf_lcu_feeder.sv
// ipf_lcu_feeder
//
// Streams a 128x128 8-bit image from a synchronous ROM to the IPF in LCU order:
// 8x8 LCUs of 16x16 pixels, LCUs in raster order (lcu_x fastest), pixels within
// an LCU in raster order (col fastest). One run per reset; start is accepted
// only in IDLE.
//
// Ports
//   clk       in   1  rising-edge clock
//   reset     in   1  asynchronous active-high reset
//   start     in   1  one-cycle pulse, begins streaming (IDLE only)
//   busy      in   1  IPF cannot accept a pixel this cycle
//   iaddr     out 14  image ROM address (registered)
//   irom_en   out  1  ROM read strobe (registered); idata valid one cycle later
//   idata     in   8  image ROM read data
//   in_en     out  1  din valid this cycle (registered)
//   din       out  8  pixel to IPF (registered)
//   lcu_x     out  3  LCU column of the pixel stream (registered)
//   lcu_y     out  3  LCU row of the pixel stream (registered)
//   lcu_size  out  2  constant 0 (16x16 LCU)
//   done      out  1  all 16384 pixels delivered (registered)
//
// Datapath: read counter -> ROM (1-cycle latency) -> 2-entry FIFO -> din.
// A read is issued only when the FIFO plus reads already in flight can still
// absorb it after this edge's pop, so a stall of any length never overflows
// the FIFO. When the FIFO is empty the returning ROM word is forwarded
// straight to din, which gives 1 pixel/cycle with only two reads in flight.

module ipf_lcu_feeder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        busy,
  output logic [13:0] iaddr,
  output logic        irom_en,
  input  logic [7:0]  idata,
  output logic        in_en,
  output logic [7:0]  din,
  output logic [2:0]  lcu_x,
  output logic [2:0]  lcu_y,
  output logic [1:0]  lcu_size,
  output logic        done
);

  localparam logic [13:0] LastPix = 14'h3fff;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Read side
  logic [13:0] rd_cnt_q, rd_cnt_d;
  logic        rd_all_q, rd_all_d;   // every read of the image has been issued
  logic [13:0] iaddr_q, iaddr_d;
  logic        irom_en_q;
  logic        rd_vld_q;             // idata holds a read result this cycle

  // FIFO
  logic [7:0]  fifo_mem_q [2];
  logic        fifo_wptr_q, fifo_rptr_q;
  logic [1:0]  fifo_cnt_q, fifo_cnt_d;

  // Output side
  logic [13:0] out_cnt_q, out_cnt_d;
  logic        in_en_q;
  logic [7:0]  din_q, din_d;
  logic [2:0]  lcu_x_q, lcu_x_d;
  logic [2:0]  lcu_y_q, lcu_y_d;
  logic        done_q;

  logic        run;
  logic        from_fifo;
  logic        deliver;
  logic        push;
  logic        pop;
  logic        issue;
  logic [2:0]  outstanding;
  logic [7:0]  pix_data;

  always_comb begin
    state_d     = state_q;
    run         = (state_q == StRun);
    from_fifo   = (fifo_cnt_q != 2'd0);
    // The pixel source is the FIFO head, or the ROM word arriving now if the
    // FIFO is empty.
    deliver     = run && !busy && (from_fifo || rd_vld_q);
    pix_data    = from_fifo ? fifo_mem_q[fifo_rptr_q] : idata;
    pop         = deliver && from_fifo;
    // A returning word is stored unless it is being forwarded to din directly.
    push        = rd_vld_q && !(deliver && !from_fifo);
    // FIFO entries plus reads in flight as they stand after this edge,
    // not counting a read issued on this edge.
    outstanding = {1'b0, fifo_cnt_q} + {2'b00, rd_vld_q} + {2'b00, irom_en_q}
                  - {2'b00, deliver};
    issue       = run && !rd_all_q && (outstanding < 3'd2);

    fifo_cnt_d  = fifo_cnt_q + {1'b0, push} - {1'b0, pop};

    rd_cnt_d    = rd_cnt_q;
    rd_all_d    = rd_all_q;
    iaddr_d     = iaddr_q;
    if (issue) begin
      // rd_cnt = {lcu_y, lcu_x, row, col}; iaddr = {lcu_y, row, lcu_x, col}
      iaddr_d  = {rd_cnt_q[13:11], rd_cnt_q[7:4], rd_cnt_q[10:8], rd_cnt_q[3:0]};
      rd_cnt_d = rd_cnt_q + 14'd1;
      if (rd_cnt_q == LastPix) begin
        rd_all_d = 1'b1;
      end
    end

    out_cnt_d   = out_cnt_q;
    din_d       = din_q;
    lcu_x_d     = lcu_x_q;
    lcu_y_d     = lcu_y_q;
    if (deliver) begin
      out_cnt_d = out_cnt_q + 14'd1;
      din_d     = pix_data;
      // LCU index follows the pixel being presented, so it changes exactly on
      // pixel 0 of each LCU and holds through any following stall.
      lcu_x_d   = out_cnt_q[10:8];
      lcu_y_d   = out_cnt_q[13:11];
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (deliver && (out_cnt_q == LastPix)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StDone;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      rd_cnt_q      <= '0;
      rd_all_q      <= 1'b0;
      iaddr_q       <= '0;
      irom_en_q     <= 1'b0;
      rd_vld_q      <= 1'b0;
      fifo_mem_q[0] <= '0;
      fifo_mem_q[1] <= '0;
      fifo_wptr_q   <= 1'b0;
      fifo_rptr_q   <= 1'b0;
      fifo_cnt_q    <= '0;
      out_cnt_q     <= '0;
      in_en_q       <= 1'b0;
      din_q         <= '0;
      lcu_x_q       <= '0;
      lcu_y_q       <= '0;
      done_q        <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_all_q   <= rd_all_d;
      iaddr_q    <= iaddr_d;
      irom_en_q  <= issue;
      rd_vld_q   <= irom_en_q;
      if (push) begin
        fifo_mem_q[fifo_wptr_q] <= idata;
        fifo_wptr_q             <= ~fifo_wptr_q;
      end
      if (pop) begin
        fifo_rptr_q <= ~fifo_rptr_q;
      end
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      in_en_q    <= deliver;
      din_q      <= din_d;
      lcu_x_q    <= lcu_x_d;
      lcu_y_q    <= lcu_y_d;
      // done rises the cycle after the last pixel is presented
      done_q     <= (state_q == StDone);
    end
  end

  assign iaddr    = iaddr_q;
  assign irom_en  = irom_en_q;
  assign in_en    = in_en_q;
  assign din      = din_q;
  assign lcu_x    = lcu_x_q;
  assign lcu_y    = lcu_y_q;
  assign lcu_size = 2'd0;
  assign done     = done_q;

endmodule
